// File: rtl/dmi_uart_ctrl_if.sv
// DMI request/response bus between the UART bridge and the Debug Module.
// The bridge drives requests and accepts responses (master); dm_top is the slave.
interface dmi_uart_ctrl_if #(
  parameter int ABITS  = 7,
  parameter int DATA_W = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ABITS+DATA_W+1:0] req;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_W+1:0]       resp;

  modport master (
    output req_valid, req, resp_ready,
    input  req_ready, resp_valid, resp
  );

  modport slave (
    input  req_valid, req, resp_ready,
    output req_ready, resp_valid, resp
  );
endinterface

// File: rtl/dmi_uart_ctrl.sv
// DMI bridge between the UART-TAP register file and the Debug Module bus.
// Adds a response timeout, a sticky error reported to the TAP, a TAP-driven
// error clear and a multi-cycle DM reset pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a TAP read, TAP write or hard reset
// CAPTURE   | latch TAP request, decide whether it goes to the DM
// REQ       | request valid to DM, waiting for ready; timeout running
// WAIT_RESP | waiting for DM response; timeout running
// ACK       | DONE_O high until the TAP drops read/write
// HRST      | DMI_RST_NO held low for RST_CYCLES cycles
module dmi_uart_ctrl #(
  parameter int ABITS      = 7,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 1024,
  parameter int RST_CYCLES = 4
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    TAP_READ_I,
  input  logic                    TAP_WRITE_I,
  input  logic [ABITS+DATA_W+1:0] DMI_I,
  output logic [ABITS+DATA_W+1:0] DMI_O,
  output logic                    DONE_O,
  input  logic                    DMI_HARD_RESET_I,
  input  logic                    DMI_CLR_ERR_I,
  dmi_uart_ctrl_if.master         dm,
  output logic                    DMI_RST_NO
);

  localparam int REQ_W = ABITS + DATA_W + 2;
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] ERR_BUSY = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_REQ,
    S_WAIT_RESP,
    S_ACK,
    S_HRST
  } state_t;

  state_t             state;
  logic [REQ_W-1:0]   req_q;
  logic [DATA_W-1:0]  resp_data_q;
  logic [1:0]         err_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [RST_W-1:0]   rst_cnt;
  logic               done_q;
  logic               req_valid_q;
  logic               resp_ready_q;
  logic               rst_n_q;

  logic               abort;
  logic [1:0]         cap_op;
  logic [1:0]         req_op;
  logic [1:0]         resp_code;
  logic [DATA_W-1:0]  resp_data;
  logic               cap_issue;

  assign cap_op    = DMI_I[1:0];
  assign req_op    = req_q[1:0];
  assign resp_code = dm.resp[1:0];
  assign resp_data = dm.resp[DATA_W+1:2];
  // Only real reads/writes reach the DM, and only while no error is pending.
  assign cap_issue = (cap_op == OP_READ || cap_op == OP_WRITE) && (err_q == 2'd0);
  // CAPTURE is short-lived, so a hard reset there is taken from REQ instead.
  assign abort     = DMI_HARD_RESET_I &&
                     (state == S_IDLE || state == S_REQ ||
                      state == S_WAIT_RESP || state == S_ACK);

  assign DMI_O          = {req_q[REQ_W-1 -: ABITS], resp_data_q, err_q};
  assign DONE_O         = done_q;
  assign DMI_RST_NO     = rst_n_q;
  assign dm.req_valid   = req_valid_q;
  assign dm.req         = req_q;
  assign dm.resp_ready  = resp_ready_q;

  // Bridge FSM with registered outputs, timeout and reset-pulse counters.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state        <= S_IDLE;
      req_q        <= '0;
      resp_data_q  <= '0;
      err_q        <= '0;
      tmo_cnt      <= '0;
      rst_cnt      <= '0;
      done_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      rst_n_q      <= 1'b1;
    end else begin
      // Clear first so that an error raised below in the same cycle wins.
      if (DMI_CLR_ERR_I && state != S_HRST) begin
        err_q <= '0;
      end
      // Saturating, so a late handshake in REQ cannot wrap the budget.
      if ((state == S_REQ || state == S_WAIT_RESP) && tmo_cnt != TMO_LAST) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (abort) begin
        state        <= S_HRST;
        req_q        <= '0;
        resp_data_q  <= '0;
        err_q        <= '0;
        rst_cnt      <= RST_LAST;
        rst_n_q      <= 1'b0;
        done_q       <= 1'b0;
        req_valid_q  <= 1'b0;
        resp_ready_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (TAP_READ_I && !TAP_WRITE_I) begin
              done_q <= 1'b1;
              state  <= S_ACK;
            end else if (TAP_WRITE_I && !TAP_READ_I) begin
              state <= S_CAPTURE;
            end
          end

          S_CAPTURE: begin
            req_q <= DMI_I;
            if (cap_issue) begin
              tmo_cnt     <= '0;
              req_valid_q <= 1'b1;
              state       <= S_REQ;
            end else begin
              done_q <= 1'b1;
              state  <= S_ACK;
            end
          end

          S_REQ: begin
            if (dm.req_ready) begin
              req_valid_q  <= 1'b0;
              resp_ready_q <= 1'b1;
              state        <= S_WAIT_RESP;
            end else if (tmo_cnt == TMO_LAST) begin
              err_q       <= ERR_BUSY;
              req_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state       <= S_ACK;
            end
          end

          S_WAIT_RESP: begin
            if (dm.resp_valid) begin
              if (req_op == OP_READ) begin
                resp_data_q <= resp_data;
              end
              // Codes 2 (failed) and 3 (busy) both have bit 1 set.
              if (resp_code[1]) begin
                err_q <= resp_code;
              end
              resp_ready_q <= 1'b0;
              done_q       <= 1'b1;
              state        <= S_ACK;
            end else if (tmo_cnt == TMO_LAST) begin
              err_q        <= ERR_BUSY;
              resp_ready_q <= 1'b0;
              done_q       <= 1'b1;
              state        <= S_ACK;
            end
          end

          S_ACK: begin
            if (!TAP_READ_I && !TAP_WRITE_I) begin
              done_q <= 1'b0;
              state  <= S_IDLE;
            end
          end

          S_HRST: begin
            if (rst_cnt == '0) begin
              rst_n_q <= 1'b1;
              state   <= S_IDLE;
            end else begin
              rst_cnt <= rst_cnt - 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmi_uart_ctrl.sv
// Scoreboard bench for dmi_uart_ctrl: TAP-side tasks predict each answer and
// request from a transaction-level model, a DM responder checks requests, and
// a DONE monitor checks every TAP answer against the expected-answer queue.
module tb_dmi_uart_ctrl;
  localparam int ABITS      = 7;
  localparam int DATA_W     = 32;
  localparam int TIMEOUT    = 16;
  localparam int RST_CYCLES = 4;
  localparam int REQ_W      = ABITS + DATA_W + 2;

  logic             CLK_I;
  logic             RST_I;
  logic             TAP_READ_I;
  logic             TAP_WRITE_I;
  logic [REQ_W-1:0] DMI_I;
  logic [REQ_W-1:0] DMI_O;
  logic             DONE_O;
  logic             DMI_HARD_RESET_I;
  logic             DMI_CLR_ERR_I;
  logic             DMI_RST_NO;

  dmi_uart_ctrl_if #(.ABITS(ABITS), .DATA_W(DATA_W)) dm_if ();

  dmi_uart_ctrl #(
    .ABITS(ABITS), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .TAP_READ_I(TAP_READ_I),
    .TAP_WRITE_I(TAP_WRITE_I),
    .DMI_I(DMI_I),
    .DMI_O(DMI_O),
    .DONE_O(DONE_O),
    .DMI_HARD_RESET_I(DMI_HARD_RESET_I),
    .DMI_CLR_ERR_I(DMI_CLR_ERR_I),
    .dm(dm_if),
    .DMI_RST_NO(DMI_RST_NO)
  );

  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model of what the TAP should read back.
  logic [ABITS-1:0]  m_addr;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_err;

  logic [REQ_W-1:0] exp_req_q[$];
  logic [REQ_W-1:0] exp_resp_q[$];

  // How the DM answers the next request.
  int                cfg_a;
  int                cfg_b;
  bit                cfg_silent;
  logic [DATA_W-1:0] cfg_rdata;
  logic [1:0]        cfg_code;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // DM responder: waits cfg_a cycles before ready, then answers cfg_b cycles
  // after the handshake with a one-cycle response pulse (unless silent).
  initial begin : dm_model
    int w;
    int lb;
    bit ls;
    logic [DATA_W-1:0] ld;
    logic [1:0] lc;
    dm_if.req_ready  = 1'b0;
    dm_if.resp_valid = 1'b0;
    dm_if.resp       = '0;
    forever begin
      @(negedge CLK_I);
      if (dm_if.req_valid === 1'b1) begin
        w  = 0;
        lb = cfg_b;
        ls = cfg_silent;
        ld = cfg_rdata;
        lc = cfg_code;
        while (dm_if.req_valid === 1'b1 && w < cfg_a) begin
          @(negedge CLK_I);
          w++;
        end
        if (dm_if.req_valid === 1'b1) begin
          if (exp_req_q.size() == 0) fail_event("dm_req_unexpected");
          else check("dm_req", 64'(dm_if.req), 64'(exp_req_q.pop_front()));
          dm_if.req_ready = 1'b1;
          @(negedge CLK_I);
          dm_if.req_ready = 1'b0;
          if (!ls) begin
            repeat (lb) @(negedge CLK_I);
            dm_if.resp       = {ld, lc};
            dm_if.resp_valid = 1'b1;
            @(negedge CLK_I);
            dm_if.resp_valid = 1'b0;
          end
        end
      end
    end
  end

  // DONE monitor: every rising DONE_O must match the oldest expected answer.
  initial begin : done_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge CLK_I);
      if (DONE_O === 1'b1 && prev !== 1'b1) begin
        if (exp_resp_q.size() == 0) fail_event("done_unexpected");
        else check("dmi_o", 64'(DMI_O), 64'(exp_resp_q.pop_front()));
      end
      prev = DONE_O;
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_done(input string name, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge CLK_I);
      n++;
    end while (DONE_O !== 1'b1 && n < 100);
    check(name, 64'(n), 64'(exp_lat));
  endtask

  task automatic tap_write(input logic [ABITS-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [1:0] op, input int a, input int b, input bit silent,
                           input logic [DATA_W-1:0] rdata, input logic [1:0] code);
    int exp_lat;
    cfg_a      = a;
    cfg_b      = b;
    cfg_silent = silent;
    cfg_rdata  = rdata;
    cfg_code   = code;
    m_addr  = addr;
    exp_lat = 2;
    if ((op == 2'd1 || op == 2'd2) && m_err == 2'd0) begin
      if (a > TIMEOUT - 2) begin
        m_err   = 2'd3;
        exp_lat = TIMEOUT + 2;
      end else begin
        exp_req_q.push_back({addr, data, op});
        // The answer must land within TIMEOUT cycles of the request going out.
        if (!silent && a + 1 + b <= TIMEOUT - 1) begin
          if (op == 2'd1) m_data = rdata;
          if (code == 2'd2 || code == 2'd3) m_err = code;
          exp_lat = a + b + 4;
        end else begin
          m_err   = 2'd3;
          exp_lat = TIMEOUT + 2;
        end
      end
    end
    exp_resp_q.push_back({m_addr, m_data, m_err});
    @(negedge CLK_I);
    DMI_I       = {addr, data, op};
    TAP_WRITE_I = 1'b1;
    wait_done("write_latency", exp_lat);
    TAP_WRITE_I = 1'b0;
  endtask

  task automatic tap_read();
    exp_resp_q.push_back({m_addr, m_data, m_err});
    @(negedge CLK_I);
    TAP_READ_I = 1'b1;
    wait_done("read_latency", 1);
    TAP_READ_I = 1'b0;
  endtask

  task automatic clr_err();
    @(negedge CLK_I);
    DMI_CLR_ERR_I = 1'b1;
    @(negedge CLK_I);
    DMI_CLR_ERR_I = 1'b0;
    m_err = 2'd0;
  endtask

  task automatic hard_reset_in_wait();
    int n_low;
    logic [ABITS-1:0] ad;
    logic [DATA_W-1:0] dt;
    ad = 7'h30;
    dt = 32'h0000_0077;
    cfg_a = 0; cfg_b = 0; cfg_silent = 1'b1; cfg_rdata = '0; cfg_code = 2'd0;
    exp_req_q.push_back({ad, dt, 2'd2});
    @(negedge CLK_I);
    DMI_I       = {ad, dt, 2'd2};
    TAP_WRITE_I = 1'b1;
    repeat (4) @(negedge CLK_I);
    check("resp_ready_in_wait", 64'(dm_if.resp_ready), 64'(1));
    DMI_HARD_RESET_I = 1'b1;
    TAP_WRITE_I      = 1'b0;
    n_low = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK_I);
      DMI_HARD_RESET_I = 1'b0;
      if (DMI_RST_NO === 1'b0) n_low++;
    end
    check("rst_pulse_len", 64'(n_low), 64'(RST_CYCLES));
    m_addr = '0; m_data = '0; m_err = 2'd0;
    check("dmi_o_after_hrst", 64'(DMI_O), 64'({m_addr, m_data, m_err}));
  endtask

  task automatic both_high_idle();
    @(negedge CLK_I);
    TAP_READ_I  = 1'b1;
    TAP_WRITE_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_I);
      check("both_high_idle", 64'({DONE_O, dm_if.req_valid}), 64'(0));
    end
    check("both_high_dmi_o", 64'(DMI_O), 64'({m_addr, m_data, m_err}));
    TAP_READ_I  = 1'b0;
    TAP_WRITE_I = 1'b0;
  endtask

  task automatic async_reset_in_req();
    cfg_a = 1000; cfg_b = 0; cfg_silent = 1'b1; cfg_rdata = '0; cfg_code = 2'd0;
    @(negedge CLK_I);
    DMI_I       = {7'h40, 32'h1234_0000, 2'd1};
    TAP_WRITE_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    check("req_valid_in_req", 64'(dm_if.req_valid), 64'(1));
    #2;
    RST_I = 1'b1;
    #1;
    check("arst_flags", 64'({DONE_O, dm_if.req_valid, dm_if.resp_ready, DMI_RST_NO}), 64'(4'b0001));
    check("arst_req", 64'(dm_if.req), 64'(0));
    check("arst_dmi_o", 64'(DMI_O), 64'(0));
    TAP_WRITE_I = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b0;
    m_addr = '0; m_data = '0; m_err = 2'd0;
  endtask

  initial begin : stimulus
    int a;
    int b;
    int r;
    bit s;
    logic [1:0] code;
    logic [ABITS-1:0] ra;

    RST_I            = 1'b1;
    TAP_READ_I       = 1'b0;
    TAP_WRITE_I      = 1'b0;
    DMI_I            = '0;
    DMI_HARD_RESET_I = 1'b0;
    DMI_CLR_ERR_I    = 1'b0;
    cfg_a = 0; cfg_b = 0; cfg_silent = 1'b0; cfg_rdata = '0; cfg_code = 2'd0;
    m_addr = '0; m_data = '0; m_err = 2'd0;
    repeat (3) @(negedge CLK_I);
    check("rst_done", 64'(DONE_O), 64'(0));
    check("rst_req_valid", 64'(dm_if.req_valid), 64'(0));
    check("rst_resp_ready", 64'(dm_if.resp_ready), 64'(0));
    check("rst_req", 64'(dm_if.req), 64'(0));
    check("rst_dmi_o", 64'(DMI_O), 64'(0));
    check("rst_rst_no", 64'(DMI_RST_NO), 64'(1));
    RST_I = 1'b0;

    // Basic write and read with an immediately ready DM.
    tap_write(7'h10, 32'hDEAD_BEEF, 2'd2, 0, 0, 1'b0, 32'h0, 2'd0);
    tap_write(7'h11, 32'h0, 2'd1, 0, 0, 1'b0, 32'h1234_5678, 2'd0);
    tap_read();

    // Silent DM: timeout sets busy, which blocks the next op until cleared.
    tap_write(7'h12, 32'h0000_CAFE, 2'd1, 0, 0, 1'b1, 32'h0, 2'd0);
    tap_write(7'h13, 32'h1, 2'd2, 0, 0, 1'b0, 32'h0, 2'd0);
    clr_err();
    tap_write(7'h13, 32'h1, 2'd2, 0, 0, 1'b0, 32'h0, 2'd0);

    // Failed response is sticky across a nop.
    tap_write(7'h14, 32'h55, 2'd2, 1, 2, 1'b0, 32'h0, 2'd2);
    tap_write(7'h15, 32'h0, 2'd0, 0, 0, 1'b0, 32'h0, 2'd0);
    tap_read();
    clr_err();

    // Response on the last allowed cycle, one cycle too late, never ready.
    tap_write(7'h20, 32'h0, 2'd1, 0, 14, 1'b0, 32'hA5A5_A5A5, 2'd0);
    tap_write(7'h21, 32'h0, 2'd1, 0, 15, 1'b0, 32'h5A5A_5A5A, 2'd0);
    tap_read();
    clr_err();
    tap_write(7'h22, 32'h9, 2'd2, 1000, 0, 1'b0, 32'h0, 2'd0);
    clr_err();

    hard_reset_in_wait();
    both_high_idle();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 3) clr_err();
      if ($urandom_range(0, 3) == 0) begin
        tap_read();
      end else begin
        r = int'($urandom_range(0, 19));
        a = (r == 0) ? 1000 : int'($urandom_range(0, 5));
        s = (r == 1 || r == 2);
        b = int'($urandom_range(0, 5));
        case ($urandom_range(0, 5))
          4:       code = 2'd2;
          5:       code = 2'd3;
          default: code = 2'd0;
        endcase
        ra = ABITS'($urandom);
        tap_write(ra, $urandom, 2'($urandom_range(0, 3)), a, b, s, $urandom, code);
      end
    end

    clr_err();
    async_reset_in_req();
    tap_write(7'h50, 32'hFEED_F00D, 2'd1, 2, 3, 1'b0, 32'h0BAD_CAFE, 2'd3);
    tap_read();

    repeat (30) @(negedge CLK_I);
    check("req_queue_drained", 64'(exp_req_q.size()), 64'(0));
    check("resp_queue_drained", 64'(exp_resp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmi_uart_ctrl.md
Name: dmi_uart_ctrl

Overview:
Parametrised DMI bridge between the UART-TAP and the Debug Module (DM) ready/valid request/response bus. It supersedes the fixed-width bridge with the following additions:
- configurable address and data widths;
- a response timeout;
- a sticky DTM error status, reported to the TAP;
- a TAP-driven error clear;
- a multi-cycle DM reset pulse.

It sits between the UART-TAP register file and dm_top.

Parameters:
ABITS, 7, DMI address width
DATA_W, 32, DMI data width
TIMEOUT, 1024, cycles allowed from request issue to DM response before flagging busy (min 2)
RST_CYCLES, 4, length in cycles of the DMI_RST_NO low pulse (min 1)

Ports:
CLK_I  in  1  clock
RST_I  in  1  asynchronous, active-high reset
TAP_READ_I  in  1  TAP requests readout of DMI_O
TAP_WRITE_I  in  1  TAP presents a new request on DMI_I
DMI_I  in  ABITS+DATA_W+2  request from TAP {addr, data, op}; op: 0 nop, 1 read, 2 write, 3 reserved
DMI_O  out  ABITS+DATA_W+2  answer to TAP {addr, data, err}; err: 0 ok, 2 failed, 3 busy
DONE_O  out  1  TAP transaction complete
DMI_HARD_RESET_I  in  1  full DMI reset request
DMI_CLR_ERR_I  in  1  single-cycle pulse that clears the sticky error
DMI_REQ_VALID_O  out  1  request valid to DM
DMI_REQ_READY_I  in  1  DM accepts request
DMI_REQ_O  out  ABITS+DATA_W+2  {addr, data, op} to DM
DMI_RESP_VALID_I  in  1  DM response valid
DMI_RESP_READY_O  out  1  bridge ready for response
DMI_RESP_I  in  DATA_W+2  {data, resp}; resp: 0 ok, 2 failed, 3 busy
DMI_RST_NO  out  1  active-low DM reset

Behaviour:
- Reset (RST_I high, asynchronous):
  - state IDLE; request, response and sticky error registers zero; timeout counter zero; reset counter zero.
  - Outputs: DONE_O=0, DMI_REQ_VALID_O=0, DMI_RESP_READY_O=0, DMI_REQ_O=0, DMI_O=0, DMI_RST_NO=1.
- DMI_O = {stored addr, stored resp data, sticky err}, all registered. DMI_REQ_O = stored request, registered.
- DMI_RESP_READY_O=1 only in WAIT_RESP. A response arriving in any other state is not accepted and is ignored.
- States:
  - IDLE:
    - DMI_HARD_RESET_I has priority and goes to HRST.
    - Else TAP_READ_I only goes to ACK.
    - Else TAP_WRITE_I only goes to CAPTURE.
    - Both high together are ignored; stay in IDLE.
  - CAPTURE: latch DMI_I into the request register.
    - op nop or reserved goes to ACK.
    - Sticky err != 0 goes to ACK without issuing the request; data is not updated.
    - Else go to REQ with the timeout counter cleared.
  - REQ: DMI_REQ_VALID_O=1, held stable until DMI_REQ_READY_I; the transfer completes in that cycle, then go to WAIT_RESP. The timeout counter runs.
  - WAIT_RESP: the timeout counter keeps running.
    - On DMI_RESP_VALID_I: read ops store the data field, write ops leave data unchanged. resp 2 or 3 sets sticky err to that value, and resp 0 leaves it unchanged. Go to ACK.
  - Timeout: when the counter reaches TIMEOUT-1 in REQ or WAIT_RESP without completion, sticky err=3. DMI_REQ_VALID_O drops the next cycle, a late DM response is never accepted, and the state goes to ACK.
  - ACK: DONE_O=1; leave to IDLE once TAP_READ_I=0 and TAP_WRITE_I=0.
  - HRST: DMI_RST_NO=0 for exactly RST_CYCLES cycles. Request, response and sticky err are cleared on entry. Go to IDLE when the pulse ends.
- Latency:
  - Read-only path: IDLE→ACK gives DONE_O 1 cycle after TAP_READ_I is seen.
  - Write with an immediately ready DM and a response in the next cycle: DONE_O 4 cycles after TAP_WRITE_I.
- DMI_CLR_ERR_I clears sticky err in any state except HRST. If it coincides with an error set in the same cycle, the set wins.
- DMI_HARD_RESET_I in REQ, WAIT_RESP or ACK aborts to HRST next cycle. DMI_REQ_VALID_O drops immediately (registered) and DONE_O is not asserted.
- The timeout counter is DATA-independent and sized clog2(TIMEOUT). It saturates and does not wrap.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, op 2; DM ready at once, resp 0 one cycle later → DMI_REQ_O={0x10, 0xDEADBEEF, 2} for 1 cycle; DONE_O high; DMI_O err=0.
- Read addr 0x11, op 1; DM resp {0x12345678, 0} → TAP_READ gives DMI_O={0x11, 0x12345678, 0}.
- TIMEOUT=16, DM never responds → DONE_O at cycle 16 after REQ entry; err=3. Next write op is not issued (DMI_REQ_VALID_O stays 0). After a DMI_CLR_ERR_I pulse, the next op issues normally.
- DM returns resp 2 on a write → err=2 sticky across a subsequent nop. A TAP read shows err=2.
- DMI_HARD_RESET_I asserted while in WAIT_RESP, RST_CYCLES=4 → DMI_RST_NO low exactly 4 cycles; DMI_O=0; DONE_O never pulses.
- TAP_READ_I and TAP_WRITE_I both high in IDLE → no state change. RST_I asserted mid-REQ → DMI_REQ_VALID_O=0 asynchronously; all outputs at reset values.
